// File: rtl/i2so_sample_fifo.sv
// Stereo sample FIFO that feeds the I2S output serializer. The head pair is presented with first-word-fall-through timing.
// Latency: a written pair appears on i2so_* one cycle after its write edge. After a pop, the next pair appears one cycle after the pop edge.
// Backpressure: there is none upstream. A write into a full FIFO with no pop is dropped and sets overflow. An rtr while empty sets underflow.
//
// Ports:
//   clk, rst                 master clock, synchronous active-high reset
//   wr_en, wr_lft, wr_rgt    one stereo pair written per cycle
//   rtr                      serializer ready-to-receive pulse; pops one pair
//   clr_err                  clears the sticky overflow/underflow flags
//   rts                      ready-to-send; set once primed, held until reset
//   i2so_lft, i2so_rgt       registered head-of-FIFO pair
//   full, empty, count       occupancy status
//   overflow, underflow      sticky error flags
module i2so_sample_fifo #(
    parameter int DEPTH       = 8,
    parameter int AW          = 3,
    parameter int START_LEVEL = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [15:0]   wr_lft,
    input  logic [15:0]   wr_rgt,
    input  logic          rtr,
    input  logic          clr_err,
    output logic          rts,
    output logic [15:0]   i2so_lft,
    output logic [15:0]   i2so_rgt,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count,
    output logic          overflow,
    output logic          underflow
);

    localparam logic [AW:0] C_DEPTH = (AW+1)'(DEPTH);
    localparam logic [AW:0] C_START = (AW+1)'(START_LEVEL);

    logic [31:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic [15:0]   r_lft;
    logic [15:0]   r_rgt;
    logic          r_rts;
    logic          r_ovf;
    logic          r_udf;

    logic          w_pop;
    logic          w_full;
    logic          w_wr_acc;
    logic          w_bypass;
    logic [AW:0]   w_cnt_nxt;
    logic [AW-1:0] w_rd_nxt;
    logic [31:0]   w_head;

    always_comb begin
        w_full    = (r_count == C_DEPTH);
        w_pop     = rtr && (r_count != '0);
        // A pop frees a slot in the same cycle, so a write into a full FIFO is accepted when a pop happens too.
        w_wr_acc  = wr_en && (!w_full || w_pop);
        w_cnt_nxt = r_count + (AW+1)'(w_wr_acc) - (AW+1)'(w_pop);
        w_rd_nxt  = r_rd_ptr + AW'(w_pop);
        // If the FIFO is empty once this cycle's pop is taken, the new head is the pair being written now.
        // That pair is not in the array yet, so it is forwarded straight from the write port.
        w_bypass  = w_wr_acc && (r_count == (AW+1)'(w_pop));
        w_head    = w_bypass ? {wr_lft, wr_rgt} : r_mem[w_rd_nxt];
    end

    // Storage is not reset. The pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            r_mem[r_wr_ptr] <= {wr_lft, wr_rgt};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_lft    <= 16'h0000;
            r_rgt    <= 16'h0000;
            r_rts    <= 1'b0;
            r_ovf    <= 1'b0;
            r_udf    <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            r_rd_ptr <= w_rd_nxt;
            r_count  <= w_cnt_nxt;
            // When the FIFO goes empty, hold the last pair so the serializer repeats it instead of outputting garbage.
            if (w_cnt_nxt != '0) begin
                r_lft <= w_head[31:16];
                r_rgt <= w_head[15:0];
            end
            // The serializer only detects the rising edge of rts, so rts never drops once it is set.
            if (w_cnt_nxt >= C_START) begin
                r_rts <= 1'b1;
            end
            // An error in the same cycle as clr_err wins over the clear.
            r_ovf <= (wr_en && w_full && !w_pop) || (r_ovf && !clr_err);
            r_udf <= (rtr && (r_count == '0))    || (r_udf && !clr_err);
        end
    end

    assign rts       = r_rts;
    assign i2so_lft  = r_lft;
    assign i2so_rgt  = r_rgt;
    assign count     = r_count;
    assign full      = w_full;
    assign empty     = (r_count == '0);
    assign overflow  = r_ovf;
    assign underflow = r_udf;

endmodule

// File: tb/tb_i2so_sample_fifo.sv
// Testbench for i2so_sample_fifo. It uses directed table vectors and hand-written corner-case sequences.
// Latency: each step drives inputs, waits for one clock edge, and checks outputs 1 time unit later.
// Backpressure: none; the bench drives rtr directly.
module tb_i2so_sample_fifo;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic [15:0] wr_lft;
    logic [15:0] wr_rgt;
    logic        rtr;
    logic        clr_err;
    logic        rts;
    logic [15:0] i2so_lft;
    logic [15:0] i2so_rgt;
    logic        full;
    logic        empty;
    logic [3:0]  count;
    logic        overflow;
    logic        underflow;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    i2so_sample_fifo #(.DEPTH(8), .AW(3), .START_LEVEL(2)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_lft(wr_lft), .wr_rgt(wr_rgt),
        .rtr(rtr), .clr_err(clr_err), .rts(rts), .i2so_lft(i2so_lft),
        .i2so_rgt(i2so_rgt), .full(full), .empty(empty), .count(count),
        .overflow(overflow), .underflow(underflow)
    );

    typedef struct {
        logic        wr;
        logic [15:0] l;
        logic [15:0] r;
        logic        rd;
        logic        clr;
        int          ecnt;
        logic [15:0] el;
        logic [15:0] er;
        logic        erts;
        logic        eovf;
        logic        eudf;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs and let one clock edge pass. On return the outputs of that edge can be sampled.
    task automatic step(input logic w, input logic [15:0] l, input logic [15:0] r,
                        input logic rd, input logic clr);
        wr_en = w; wr_lft = l; wr_rgt = r; rtr = rd; clr_err = clr;
        @(posedge clk);
        #1;
        wr_en = 1'b0; rtr = 1'b0; clr_err = 1'b0;
    endtask

    task automatic chk_state(input string tag, input int ecnt, input logic [15:0] el,
                             input logic [15:0] er, input logic erts,
                             input logic eovf, input logic eudf);
        chk({tag, ".count"}, {12'b0, count}, 16'(ecnt));
        chk({tag, ".full"}, {15'b0, full}, {15'b0, ecnt == 8});
        chk({tag, ".empty"}, {15'b0, empty}, {15'b0, ecnt == 0});
        chk({tag, ".lft"}, i2so_lft, el);
        chk({tag, ".rgt"}, i2so_rgt, er);
        chk({tag, ".rts"}, {15'b0, rts}, {15'b0, erts});
        chk({tag, ".ovf"}, {15'b0, overflow}, {15'b0, eovf});
        chk({tag, ".udf"}, {15'b0, underflow}, {15'b0, eudf});
    endtask

    function automatic logic [15:0] pl(input int k);
        return 16'(k * 'h1111);
    endfunction

    function automatic logic [15:0] pr(input int k);
        return 16'h0A00 | 16'(k);
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        step(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b0; wr_en = 1'b0; wr_lft = '0; wr_rgt = '0; rtr = 1'b0; clr_err = 1'b0;

        // Fill and prime: rts rises on the second write. Then three pops, each showing the next pair.
        vecs[0] = '{1'b1, 16'h1111, 16'hAAAA, 1'b0, 1'b0, 1, 16'h1111, 16'hAAAA, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 16'h2222, 16'hBBBB, 1'b0, 1'b0, 2, 16'h1111, 16'hAAAA, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 16'h3333, 16'hCCCC, 1'b0, 1'b0, 3, 16'h1111, 16'hAAAA, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 16'h4444, 16'hDDDD, 1'b0, 1'b0, 4, 16'h1111, 16'hAAAA, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 3, 16'h2222, 16'hBBBB, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 2, 16'h3333, 16'hCCCC, 1'b1, 1'b0, 1'b0};
        vecs[6] = '{1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1, 16'h4444, 16'hDDDD, 1'b1, 1'b0, 1'b0};

        do_reset();
        chk_state("init_reset", 0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 7; i++) begin
            step(vecs[i].wr, vecs[i].l, vecs[i].r, vecs[i].rd, vecs[i].clr);
            chk_state($sformatf("vec%0d", i), vecs[i].ecnt, vecs[i].el, vecs[i].er,
                      vecs[i].erts, vecs[i].eovf, vecs[i].eudf);
        end

        // Reset in the middle of traffic: one pair is still stored and rts is set.
        do_reset();
        chk_state("mid_reset", 0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);

        // Overflow: write nine pairs with no pops. The ninth pair is dropped.
        for (int k = 1; k <= 8; k++) begin
            step(1'b1, pl(k), pr(k), 1'b0, 1'b0);
        end
        chk_state("fill8", 8, pl(1), pr(1), 1'b1, 1'b0, 1'b0);
        step(1'b1, pl(9), pr(9), 1'b0, 1'b0);
        chk_state("ovf9", 8, pl(1), pr(1), 1'b1, 1'b1, 1'b0);
        step(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
        chk_state("ovf_clr", 8, pl(1), pr(1), 1'b1, 1'b0, 1'b0);
        // A write and a pop together while full: the write is accepted and overflow stays clear.
        step(1'b1, pl(10), pr(10), 1'b1, 1'b0);
        chk_state("full_wr_pop", 8, pl(2), pr(2), 1'b1, 1'b0, 1'b0);
        // Drain: pairs 3..8 then 10 should emerge, never pair 9.
        for (int j = 1; j <= 8; j++) begin
            int nk;
            nk = (j <= 6) ? j + 2 : 10;
            step(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
            chk_state($sformatf("drain%0d", j), 8 - j, pl(nk), pr(nk), 1'b1, 1'b0, 1'b0);
        end

        // Underflow while empty: the output holds the last pair and rts stays set.
        step(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
        chk_state("udf", 0, pl(10), pr(10), 1'b1, 1'b0, 1'b1);
        step(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
        chk_state("udf_clr", 0, pl(10), pr(10), 1'b1, 1'b0, 1'b0);
        step(1'b0, 16'h0, 16'h0, 1'b1, 1'b1);
        chk_state("udf_clr_win", 0, pl(10), pr(10), 1'b1, 1'b0, 1'b1);
        step(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
        chk_state("udf_clr2", 0, pl(10), pr(10), 1'b1, 1'b0, 1'b0);
        // A write into an empty FIFO together with rtr: the write lands, the pop is refused, underflow is set.
        step(1'b1, 16'h5555, 16'h6666, 1'b1, 1'b0);
        chk_state("empty_wr_rtr", 1, 16'h5555, 16'h6666, 1'b1, 1'b0, 1'b1);

        // Wrap: stream 20 pairs through with occupancy between 1 and 3.
        do_reset();
        begin
            logic [15:0] dl[20];
            logic [15:0] dr[20];
            int w, r, occ, cyc;
            logic dw, dd;
            for (int i = 0; i < 20; i++) begin
                dl[i] = 16'h1000 + 16'(i * 'h0101);
                dr[i] = ~dl[i];
            end
            w = 0; r = 0; cyc = 0;
            while (r < 20 && cyc < 200) begin
                occ = w - r;
                dd = (occ > 0) && (occ >= 3 || w == 20 || (occ >= 2 && (cyc % 3) != 0));
                dw = (w < 20) && (occ < 3 || dd);
                step(dw, (w < 20) ? dl[w] : 16'h0, (w < 20) ? dr[w] : 16'h0, dd, 1'b0);
                if (dw) w++;
                if (dd) r++;
                cyc++;
                chk($sformatf("wrap%0d.count", cyc), {12'b0, count}, 16'(w - r));
                if (w - r > 0) begin
                    chk($sformatf("wrap%0d.lft", cyc), i2so_lft, dl[r]);
                    chk($sformatf("wrap%0d.rgt", cyc), i2so_rgt, dr[r]);
                end
            end
            n_checks++;
            if (r != 20) begin
                n_errors++;
                $display("FAIL wrap_done: popped %0d expected 20", r);
            end
            chk("wrap.ovf", {15'b0, overflow}, 16'h0);
            chk("wrap.udf", {15'b0, underflow}, 16'h0);
            chk("wrap.lft_hold", i2so_lft, dl[19]);
            chk("wrap.rts", {15'b0, rts}, 16'h1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/i2so_sample_fifo.md
Name: i2so_sample_fifo

Overview:
- Stereo sample buffer directly upstream of the I2S output serializer.
- Accepts 16-bit left/right sample pairs from the audio datapath and stores them in a DEPTH-entry FIFO.
- Presents the head pair on i2so_lft/i2so_rgt with first-word-fall-through timing.
- Raises rts once primed and pops one pair per serializer rtr pulse; overflow and underflow are flagged with sticky bits.

Parameters:
DEPTH, 8, number of stereo pairs stored; power of two, minimum 2
AW, 3, pointer width, log2(DEPTH)
START_LEVEL, 2, occupancy (1..DEPTH) at which rts is first asserted

Ports:
clk  in  1  master clock; same clock as the serializer
rst  in  1  reset; synchronous, active-high
wr_en  in  1  write strobe; one pair per cycle
wr_lft  in  16  left sample to write
wr_rgt  in  16  right sample to write
rtr  in  1  serializer ready-to-receive; 1-cycle pulse once per frame
clr_err  in  1  clears the sticky error flags
rts  out  1  ready-to-send to the serializer
i2so_lft  out  16  head-of-FIFO left sample
i2so_rgt  out  16  head-of-FIFO right sample
full  out  1  count == DEPTH
empty  out  1  count == 0
count  out  AW+1  current occupancy, 0..DEPTH
overflow  out  1  sticky: a write was dropped
underflow  out  1  sticky: rtr arrived while empty

Behaviour:
- Reset: one clock with rst=1.
  - Pointers and count go to 0; rts, overflow and underflow go to 0.
  - i2so_lft and i2so_rgt go to 16'h0000; empty=1, full=0.
  - Reset mid-operation discards all stored data. Storage array contents need not be reset.
- Storage: DEPTH x 32-bit array, {lft, rgt} per entry. wr_ptr and rd_ptr are AW bits and wrap modulo DEPTH.
- Write: on a clk edge with wr_en=1 and (count<DEPTH or pop this cycle), the pair is stored at wr_ptr and wr_ptr increments.
  - wr_en=1 with count==DEPTH and no pop: the pair is dropped and overflow is set.
- Pop: on a clk edge with rtr=1 and count>0, rd_ptr increments.
  - rtr=1 with count==0: no pop; underflow is set.
- Count: count += write_accepted - pop_done.
  - Simultaneous write and pop leaves count unchanged. This is the case when full, when the write is accepted.
  - Write while empty plus rtr in the same cycle: the write is accepted (count becomes 1), the pop is refused and underflow is set.
- Output registers: i2so_lft/i2so_rgt are registered.
  - Each cycle they load the entry at the next-state rd_ptr when the next-state count > 0.
  - Otherwise they hold their last value, so the serializer repeats the previous pair on underflow and no garbage is output.
  - Latency: a write into an empty FIFO is visible on i2so_* on the cycle after the write edge (1-cycle fall-through).
  - After a pop edge, the next pair is valid one cycle later. This is well before the serializer's next capture, which is about one frame away.
  - The serializer samples i2so_* on the same edge at which it asserts rtr, so the pair being popped is the pair already captured.
- rts:
  - Set on the edge where next-state count >= START_LEVEL.
  - Once set, stays 1 until rst, even if the FIFO drains, because the serializer only detects a rising edge of rts and never returns to idle.
  - Underflow after start is reported only by the flag.
- Sticky flags: overflow and underflow clear on clr_err=1. An error event in the same cycle as clr_err wins, so the flag stays 1.
- full and empty are combinational decodes of the registered count.
- No state depends on rtr width: an rtr held for N cycles pops N pairs. The serializer guarantees single-cycle pulses.

Test Plan:
- Reset: hold rst=1 for 1 cycle after arbitrary traffic -> count=0, empty=1, rts=0, i2so_lft=i2so_rgt=16'h0000, flags=0.
- Fill/prime: write (16'h1111,16'hAAAA), then (16'h2222,16'hBBBB) -> i2so_lft=16'h1111 one cycle after the first write; rts=1 on the edge of the second write; count=2.
- Pop order: pulse rtr three times with 4 pairs stored -> i2so_lft sequence 1111, 2222, 3333, 4444 (each one cycle after its rtr pulse); count=1; rts stays 1.
- Overflow: write 9 pairs into DEPTH=8 with no rtr -> count=8, full=1, overflow=1, 9th pair absent on later pops. Then write+rtr in the same cycle while full -> count stays 8, the write is accepted, no new overflow.
- Underflow: drain to empty then pulse rtr -> underflow=1, i2so_* hold the last popped pair, count=0, rts=1. Then clr_err=1 -> underflow=0. clr_err coincident with another empty rtr -> underflow stays 1.
- Wrap: stream 20 pairs through with occupancy 1..3 -> all 20 pairs emerge in order across pointer wrap; no flags set.
